// File: rtl/nexus_block_free_list_if.sv
`default_nettype none
// ============================================================================
//  Module   : nexus_block_free_list_if
//  Purpose  : Request/response bundle for the SRAM block free-list manager:
//             alloc handshake, free request, quota write and status.
//  Revision : 1.0  initial release
// ============================================================================
interface nexus_block_free_list_if #(
  parameter int ADW  = 10,
  parameter int TIDW = 4,
  parameter int CNTW = 11
);
  logic            alloc_req;
  logic [TIDW-1:0] alloc_tenant;
  logic            alloc_ready;
  logic            alloc_valid;
  logic [ADW-1:0]  alloc_addr;
  logic            alloc_err;
  logic            free_req;
  logic [TIDW-1:0] free_tenant;
  logic [ADW-1:0]  free_addr;
  logic            free_err;
  logic            quota_we;
  logic [TIDW-1:0] quota_tenant;
  logic [CNTW-1:0] quota_val;
  logic [CNTW-1:0] free_count;
  logic            init_done;

  // Requester side: drives requests, observes responses and status
  modport master (
    output alloc_req, alloc_tenant, free_req, free_tenant, free_addr,
           quota_we, quota_tenant, quota_val,
    input  alloc_ready, alloc_valid, alloc_addr, alloc_err, free_err,
           free_count, init_done
  );

  // Free-list side: consumes requests, produces responses and status
  modport slave (
    input  alloc_req, alloc_tenant, free_req, free_tenant, free_addr,
           quota_we, quota_tenant, quota_val,
    output alloc_ready, alloc_valid, alloc_addr, alloc_err, free_err,
           free_count, init_done
  );
endinterface
`default_nettype wire

// File: rtl/nexus_block_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : nexus_block_free_list
//  Purpose  : Ring-based free list of physical SRAM block addresses with
//             per-tenant quota enforcement. Populates itself after reset,
//             then serves allocs (1-cycle registered response) and frees.
//  Revision : 1.0  initial release
// ============================================================================
module nexus_block_free_list #(
  parameter int SRAM_BLOCKS = 1024,
  parameter int ADW         = 10,
  parameter int TENANTS     = 16,
  parameter int TIDW        = 4,
  parameter int CNTW        = 11
) (
  input  wire logic               clk,
  input  wire logic               rst,
  nexus_block_free_list_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] c_full = CNTW'(SRAM_BLOCKS);
  localparam logic [CNTW-1:0] c_last = CNTW'(SRAM_BLOCKS - 1);

  state_t          r_state;
  logic [ADW-1:0]  r_ring [SRAM_BLOCKS];
  logic [ADW-1:0]  r_head;
  logic [ADW-1:0]  r_tail;
  logic [CNTW-1:0] r_count;
  logic [CNTW-1:0] r_usage [TENANTS];
  logic [CNTW-1:0] r_quota [TENANTS];
  logic            r_alloc_valid;
  logic            r_alloc_err;
  logic [ADW-1:0]  r_alloc_addr;
  logic            r_free_err;

  logic w_ready;
  logic w_alloc_fire;
  logic w_alloc_ok;
  logic w_free_ok;
  logic w_init_last;

  // Accept/refuse decisions, all taken against pre-cycle count, usage, quota
  always_comb begin
    w_ready      = (r_state == ST_READY);
    w_alloc_fire = w_ready && bus.alloc_req;
    w_alloc_ok   = w_alloc_fire && (r_count != '0) &&
                   (r_usage[bus.alloc_tenant] < r_quota[bus.alloc_tenant]);
    w_free_ok    = w_ready && bus.free_req &&
                   (r_usage[bus.free_tenant] != '0) && (r_count != c_full);
    w_init_last  = (r_state == ST_INIT) && (r_count == c_last);
  end

  // Ring storage: identity fill during INIT, pushes of released blocks after
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_ring[r_tail] <= r_tail;
    end else if (w_free_ok) begin
      r_ring[r_tail] <= bus.free_addr;
    end
  end

  // Control state, pointers, counters, quotas and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_alloc_valid <= 1'b0;
      r_alloc_err   <= 1'b0;
      r_alloc_addr  <= '0;
      r_free_err    <= 1'b0;
      for (int t = 0; t < TENANTS; t++) begin
        r_usage[t] <= '0;
        r_quota[t] <= c_full;
      end
    end else begin
      r_alloc_valid <= w_alloc_fire;
      r_alloc_err   <= w_alloc_fire && !w_alloc_ok;
      r_alloc_addr  <= w_alloc_ok ? r_ring[r_head] : '0;
      // Any free not accepted (including all frees during INIT) is flagged
      r_free_err    <= bus.free_req && !w_free_ok;

      case (r_state)
        ST_INIT: begin
          r_tail  <= r_tail + ADW'(1);
          r_count <= r_count + CNTW'(1);
          if (w_init_last) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (w_alloc_ok) begin
            r_head <= r_head + ADW'(1);
          end
          if (w_free_ok) begin
            r_tail <= r_tail + ADW'(1);
          end
          r_count <= r_count + CNTW'(w_free_ok) - CNTW'(w_alloc_ok);
        end
        default: r_state <= ST_INIT;
      endcase

      // Same-tenant alloc and free in one cycle cancel out
      for (int t = 0; t < TENANTS; t++) begin
        r_usage[t] <= r_usage[t]
                    + CNTW'(w_alloc_ok && (bus.alloc_tenant == TIDW'(t)))
                    - CNTW'(w_free_ok  && (bus.free_tenant  == TIDW'(t)));
        if (bus.quota_we && (bus.quota_tenant == TIDW'(t))) begin
          r_quota[t] <= bus.quota_val;
        end
      end
    end
  end

  assign bus.alloc_ready = (r_state == ST_READY);
  assign bus.init_done   = (r_state == ST_READY);
  assign bus.alloc_valid = r_alloc_valid;
  assign bus.alloc_err   = r_alloc_err;
  assign bus.alloc_addr  = r_alloc_addr;
  assign bus.free_err    = r_free_err;
  assign bus.free_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_nexus_block_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nexus_block_free_list
//  Purpose  : Directed self-checking bench for the SRAM block free list.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nexus_block_free_list;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nexus_block_free_list_if #(.ADW(10), .TIDW(4), .CNTW(11)) bus ();

  nexus_block_free_list #(
    .SRAM_BLOCKS(1024), .ADW(10), .TENANTS(16), .TIDW(4), .CNTW(11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle alloc request; returns the response seen one cycle later
  task automatic do_alloc(input logic [3:0] t, output logic v, output logic e,
                          output logic [9:0] a);
    bus.alloc_req    = 1'b1;
    bus.alloc_tenant = t;
    tick();
    v = bus.alloc_valid;
    e = bus.alloc_err;
    a = bus.alloc_addr;
    bus.alloc_req = 1'b0;
  endtask

  task automatic do_free(input logic [3:0] t, input logic [9:0] addr, output logic e);
    bus.free_req    = 1'b1;
    bus.free_tenant = t;
    bus.free_addr   = addr;
    tick();
    e = bus.free_err;
    bus.free_req = 1'b0;
  endtask

  task automatic do_quota(input logic [3:0] t, input logic [10:0] q);
    bus.quota_we     = 1'b1;
    bus.quota_tenant = t;
    bus.quota_val    = q;
    tick();
    bus.quota_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.alloc_ready); end
    checks++; if (bus.alloc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.alloc_valid); end
    checks++; if (bus.free_count !== 11'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.free_count); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b exp=0", bus.init_done); end
  endtask

  // Alloc is held high throughout INIT and must be ignored; one free at cycle 5
  task automatic test_init();
    logic exp_ferr;
    bus.alloc_req    = 1'b1;
    bus.alloc_tenant = 4'd0;
    for (int k = 1; k <= 1024; k++) begin
      bus.free_req    = (k == 5);
      bus.free_tenant = 4'd0;
      bus.free_addr   = 10'd3;
      exp_ferr        = (k == 5);
      tick();
      checks++; if (bus.free_count !== 11'(k)) begin errors++; $display("FAIL init_count k=%0d got=%0d exp=%0d", k, bus.free_count, k); end
      checks++; if (bus.alloc_valid !== 1'b0) begin errors++; $display("FAIL init_alloc_ignored k=%0d got=%b exp=0", k, bus.alloc_valid); end
      checks++; if (bus.free_err !== exp_ferr) begin errors++; $display("FAIL init_free_err k=%0d got=%b exp=%b", k, bus.free_err, exp_ferr); end
      if (k < 1024) begin
        checks++; if (bus.alloc_ready !== 1'b0 || bus.init_done !== 1'b0) begin errors++; $display("FAIL init_ready k=%0d got=%b/%b exp=0/0", k, bus.alloc_ready, bus.init_done); end
      end else begin
        checks++; if (bus.alloc_ready !== 1'b1 || bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done k=%0d got=%b/%b exp=1/1", k, bus.alloc_ready, bus.init_done); end
      end
    end
    bus.alloc_req = 1'b0;
    bus.free_req  = 1'b0;
  endtask

  task automatic test_basic_alloc();
    logic v, e;
    logic [9:0] a;
    for (int i = 0; i < 3; i++) begin
      do_alloc(4'd0, v, e, a);
      checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'(i)) begin errors++; $display("FAIL basic_alloc%0d got=v%b e%b a%0d exp=v1 e0 a%0d", i, v, e, a, i); end
    end
    tick();
    checks++; if (bus.alloc_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", bus.alloc_valid); end
    checks++; if (bus.free_count !== 11'd1021) begin errors++; $display("FAIL basic_count got=%0d exp=1021", bus.free_count); end
  endtask

  task automatic test_quota();
    logic v, e;
    logic [9:0] a;
    do_quota(4'd3, 11'd2);
    do_alloc(4'd3, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'd3) begin errors++; $display("FAIL quota_a1 got=v%b e%b a%0d exp=v1 e0 a3", v, e, a); end
    do_alloc(4'd3, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'd4) begin errors++; $display("FAIL quota_a2 got=v%b e%b a%0d exp=v1 e0 a4", v, e, a); end
    do_alloc(4'd3, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b1 || a !== 10'd0) begin errors++; $display("FAIL quota_over got=v%b e%b a%0d exp=v1 e1 a0", v, e, a); end
    checks++; if (bus.free_count !== 11'd1019) begin errors++; $display("FAIL quota_count got=%0d exp=1019", bus.free_count); end
    // Quota write and alloc in the same cycle: the old quota applies
    bus.quota_we     = 1'b1;
    bus.quota_tenant = 4'd4;
    bus.quota_val    = 11'd0;
    do_alloc(4'd4, v, e, a);
    bus.quota_we = 1'b0;
    checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'd5) begin errors++; $display("FAIL quota_old_used got=v%b e%b a%0d exp=v1 e0 a5", v, e, a); end
    do_alloc(4'd4, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL quota_new_used got=v%b e%b exp=v1 e1", v, e); end
    checks++; if (bus.free_count !== 11'd1018) begin errors++; $display("FAIL quota_count2 got=%0d exp=1018", bus.free_count); end
  endtask

  task automatic test_free_err();
    logic e;
    do_free(4'd7, 10'd9, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL free_zero_usage got=%b exp=1", e); end
    tick();
    checks++; if (bus.free_err !== 1'b0) begin errors++; $display("FAIL free_err_pulse got=%b exp=0", bus.free_err); end
    checks++; if (bus.free_count !== 11'd1018) begin errors++; $display("FAIL free_err_count got=%0d exp=1018", bus.free_count); end
  endtask

  task automatic test_exhaust();
    logic v, e;
    logic [9:0] a;
    for (int i = 0; i < 1018; i++) begin
      do_alloc(4'd0, v, e, a);
      checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'(i + 6)) begin errors++; $display("FAIL exhaust_alloc%0d got=v%b e%b a%0d exp=v1 e0 a%0d", i, v, e, a, i + 6); end
    end
    checks++; if (bus.free_count !== 11'd0) begin errors++; $display("FAIL exhaust_count got=%0d exp=0", bus.free_count); end
    do_alloc(4'd0, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b1 || a !== 10'd0) begin errors++; $display("FAIL exhaust_empty got=v%b e%b a%0d exp=v1 e1 a0", v, e, a); end
    do_free(4'd0, 10'd5, e);
    checks++; if (e !== 1'b0 || bus.free_count !== 11'd1) begin errors++; $display("FAIL exhaust_free got=e%b c%0d exp=e0 c1", e, bus.free_count); end
    do_alloc(4'd0, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'd5) begin errors++; $display("FAIL exhaust_wrap got=v%b e%b a%0d exp=v1 e0 a5", v, e, a); end
  endtask

  task automatic test_simultaneous();
    logic v, e, fe;
    logic [9:0] a;
    do_free(4'd0, 10'd100, e);
    do_alloc(4'd1, v, e, a);
    checks++; if (e !== 1'b0 || a !== 10'd100 || bus.free_count !== 11'd0) begin errors++; $display("FAIL sim_setup got=e%b a%0d c%0d exp=e0 a100 c0", e, a, bus.free_count); end
    // Empty list: alloc refused even though a free arrives the same cycle
    bus.free_req = 1'b1; bus.free_tenant = 4'd1; bus.free_addr = 10'd100;
    do_alloc(4'd1, v, e, a);
    fe = bus.free_err;
    bus.free_req = 1'b0;
    checks++; if (v !== 1'b1 || e !== 1'b1 || a !== 10'd0) begin errors++; $display("FAIL sim_empty_alloc got=v%b e%b a%0d exp=v1 e1 a0", v, e, a); end
    checks++; if (fe !== 1'b0 || bus.free_count !== 11'd1) begin errors++; $display("FAIL sim_empty_free got=fe%b c%0d exp=fe0 c1", fe, bus.free_count); end
    for (int i = 0; i < 10; i++) do_free(4'd0, 10'(201 + i), e);
    do_alloc(4'd1, v, e, a);
    checks++; if (a !== 10'd100 || bus.free_count !== 11'd10) begin errors++; $display("FAIL sim_setup2 got=a%0d c%0d exp=a100 c10", a, bus.free_count); end
    // Same tenant alloc+free with count 10: count and usage unchanged
    bus.free_req = 1'b1; bus.free_tenant = 4'd1; bus.free_addr = 10'd300;
    do_alloc(4'd1, v, e, a);
    fe = bus.free_err;
    bus.free_req = 1'b0;
    checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'd201 || fe !== 1'b0) begin errors++; $display("FAIL sim_both got=v%b e%b a%0d fe%b exp=v1 e0 a201 fe0", v, e, a, fe); end
    checks++; if (bus.free_count !== 11'd10) begin errors++; $display("FAIL sim_count got=%0d exp=10", bus.free_count); end
    // usage[1] must be exactly 1: quota 1 blocks, one free succeeds, second fails
    do_quota(4'd1, 11'd1);
    do_alloc(4'd1, v, e, a);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sim_usage_ge1 got=e%b exp=e1", e); end
    do_free(4'd1, 10'd7, e);
    checks++; if (e !== 1'b0 || bus.free_count !== 11'd11) begin errors++; $display("FAIL sim_usage_free1 got=e%b c%0d exp=e0 c11", e, bus.free_count); end
    do_free(4'd1, 10'd8, e);
    checks++; if (e !== 1'b1 || bus.free_count !== 11'd11) begin errors++; $display("FAIL sim_usage_free2 got=e%b c%0d exp=e1 c11", e, bus.free_count); end
  endtask

  task automatic test_reset_mid();
    logic v, e;
    logic [9:0] a;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    checks++; if (bus.free_count !== 11'd500) begin errors++; $display("FAIL mid_init_count got=%0d exp=500", bus.free_count); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (bus.free_count !== 11'd0 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL mid_init_reset got=c%0d r%b exp=c0 r0", bus.free_count, bus.alloc_ready); end
    for (int i = 0; i < 1024; i++) tick();
    checks++; if (bus.init_done !== 1'b1 || bus.free_count !== 11'd1024) begin errors++; $display("FAIL mid_reinit got=d%b c%0d exp=d1 c1024", bus.init_done, bus.free_count); end
    for (int i = 0; i < 100; i++) do_alloc(4'd0, v, e, a);
    checks++; if (a !== 10'd99 || bus.free_count !== 11'd924) begin errors++; $display("FAIL mid_allocs got=a%0d c%0d exp=a99 c924", a, bus.free_count); end
    rst = 1'b1; bus.alloc_req = 1'b1; bus.alloc_tenant = 4'd0;
    tick();
    rst = 1'b0; bus.alloc_req = 1'b0;
    checks++; if (bus.alloc_valid !== 1'b0 || bus.free_count !== 11'd0 || bus.init_done !== 1'b0 || bus.alloc_addr !== 10'd0) begin errors++; $display("FAIL mid_ready_reset got=v%b c%0d d%b a%0d exp=v0 c0 d0 a0", bus.alloc_valid, bus.free_count, bus.init_done, bus.alloc_addr); end
    for (int i = 0; i < 1024; i++) tick();
    // Quotas are back to full: tenant 1 (previously quota 1) gets two blocks
    do_alloc(4'd1, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'd0) begin errors++; $display("FAIL mid_first_alloc got=v%b e%b a%0d exp=v1 e0 a0", v, e, a); end
    do_alloc(4'd1, v, e, a);
    checks++; if (v !== 1'b1 || e !== 1'b0 || a !== 10'd1) begin errors++; $display("FAIL mid_quota_restored got=v%b e%b a%0d exp=v1 e0 a1", v, e, a); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst              = 1'b0;
    bus.alloc_req    = 1'b0;
    bus.alloc_tenant = '0;
    bus.free_req     = 1'b0;
    bus.free_tenant  = '0;
    bus.free_addr    = '0;
    bus.quota_we     = 1'b0;
    bus.quota_tenant = '0;
    bus.quota_val    = '0;
    test_reset();
    test_init();
    test_basic_alloc();
    test_quota();
    test_free_err();
    test_exhaust();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
